coefficient_encoder: RTL and testbench

COEFFICIENT_ENCODER -- requirements
Module: coefficient_encoder

---
 rtl/coefficient_encoder.sv | 47 ++++
 tb/tb_coefficient_encoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/coefficient_encoder.sv
// JPEG magnitude-category encoder: one coefficient in, (code bits, SSSS) out
// one cycle later. Fully pipelined, no backpressure.
module coefficient_encoder (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] coefficient,
    input  logic        in_valid,
    output logic [15:0] coded_value,
    output logic [3:0]  coded_value_length,
    output logic        out_valid
);

    logic        neg;
    logic [15:0] sat;
    logic [15:0] mag;
    logic [3:0]  ssss;
    logic [15:0] mask;
    logic [15:0] code;

    always_comb begin
        neg = coefficient[15];
        // -32768 has no positive magnitude in 16 bits; clamp to -32767
        sat = (coefficient == 16'h8000) ? 16'h8001 : coefficient;
        mag = neg ? (16'd0 - sat) : sat;
        ssss = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (mag[i]) ssss = 4'(i + 1);
        end
        mask = (16'd1 << ssss) - 16'd1;
        code = (neg ? (sat - 16'd1) : sat) & mask;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            coded_value        <= 16'd0;
            coded_value_length <= 4'd0;
            out_valid          <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                coded_value        <= code;
                coded_value_length <= ssss;
            end
        end
    end

endmodule

// File: tb/tb_coefficient_encoder.sv
// Self-checking bench for coefficient_encoder: directed table,
// hold/idle, reset and exhaustive sweeps against a reference model.
module tb_coefficient_encoder;

    logic        clock;
    logic        reset_n;
    logic [15:0] coefficient;
    logic        in_valid;
    logic [15:0] coded_value;
    logic [3:0]  coded_value_length;
    logic        out_valid;

    int checks;
    int errors;

    coefficient_encoder dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .coefficient        (coefficient),
        .in_valid           (in_valid),
        .coded_value        (coded_value),
        .coded_value_length (coded_value_length),
        .out_valid          (out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] coef;
        logic [15:0] code;
        logic [3:0]  len;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [15:0] exp_code,
                         input logic [3:0] exp_len, input logic exp_v);
        checks++;
        if (coded_value !== exp_code || coded_value_length !== exp_len ||
            out_valid !== exp_v) begin
            errors++;
            $display("FAIL %s: got code=%h len=%0d v=%b, want code=%h len=%0d v=%b",
                     name, coded_value, coded_value_length, out_valid,
                     exp_code, exp_len, exp_v);
        end
    endtask

    function automatic void ref_model(input logic [15:0] c,
                                      output logic [15:0] code,
                                      output logic [3:0] len);
        int v;
        int m;
        int n;
        v = int'($signed(c));
        if (v == -32768) v = -32767;
        m = (v < 0) ? -v : v;
        n = 0;
        while (m > (1 << n) - 1) n++;
        len = 4'(n);
        if (v >= 0) code = 16'(v);
        else code = 16'(v + (1 << n) - 1);
    endfunction

    task automatic drive(input logic [15:0] c, input logic v);
        @(negedge clock);
        coefficient = c;
        in_valid = v;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [15:0] ec;
        logic [3:0]  el;

        checks = 0;
        errors = 0;

        vecs[0]  = '{16'hFFFF, 16'h0000, 4'd1};
        vecs[1]  = '{16'h0001, 16'h0001, 4'd1};
        vecs[2]  = '{16'h0000, 16'h0000, 4'd0};
        vecs[3]  = '{16'hFFFB, 16'h0002, 4'd3};
        vecs[4]  = '{16'h0006, 16'h0006, 4'd3};
        vecs[5]  = '{16'hFFD2, 16'h0011, 4'd6};
        vecs[6]  = '{16'h003F, 16'h003F, 4'd6};
        vecs[7]  = '{16'hFFC1, 16'h0000, 4'd6};
        vecs[8]  = '{16'h03FF, 16'h03FF, 4'd10};
        vecs[9]  = '{16'hFC01, 16'h0000, 4'd10};
        vecs[10] = '{16'h0040, 16'h0040, 4'd7};
        vecs[11] = '{16'hFFC0, 16'h003F, 4'd7};
        vecs[12] = '{16'h7FFF, 16'h7FFF, 4'd15};
        vecs[13] = '{16'h8001, 16'h0000, 4'd15};
        vecs[14] = '{16'h8000, 16'h0000, 4'd15};
        vecs[15] = '{16'h4000, 16'h4000, 4'd15};

        reset_n = 1'b0;
        coefficient = 16'h1234;
        in_valid = 1'b1;
        #1;
        check("reset_state", 16'h0000, 4'd0, 1'b0);
        @(posedge clock);
        #1;
        check("reset_held", 16'h0000, 4'd0, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        reset_n = 1'b1;

        // back-to-back directed vectors
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].coef, 1'b1);
            check($sformatf("vec%0d_%h", i, vecs[i].coef),
                  vecs[i].code, vecs[i].len, 1'b1);
        end

        // valid, idle, valid
        drive(16'h0006, 1'b1);
        check("hs_first", 16'h0006, 4'd3, 1'b1);
        drive(16'hFFFB, 1'b0);
        check("hs_idle_hold", 16'h0006, 4'd3, 1'b0);
        drive(16'hFFFB, 1'b1);
        check("hs_second", 16'h0002, 4'd3, 1'b1);

        // async reset mid-stream
        drive(16'h003F, 1'b1);
        check("rst_pre", 16'h003F, 4'd6, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_clear", 16'h0000, 4'd0, 1'b0);
        @(posedge clock);
        #1;
        check("rst_discard", 16'h0000, 4'd0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        check("rst_release_idle", 16'h0000, 4'd0, 1'b0);
        drive(16'hFFC0, 1'b1);
        check("rst_first_valid", 16'h003F, 4'd7, 1'b1);

        // exhaustive sweep, back-to-back
        for (int i = 0; i < 65536; i++) begin
            drive(16'(i), 1'b1);
            ref_model(16'(i), ec, el);
            check($sformatf("sweep_%h", 16'(i)), ec, el, 1'b1);
            checks += 0;
            if (coded_value[15] !== 1'b0) begin
                errors++;
                $display("FAIL sweep_bit15_%h: got %b want 0", 16'(i),
                         coded_value[15]);
            end
        end

        @(negedge clock);
        in_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
